pending_req_arbiter: RTL and testbench

PENDING_REQ_ARBITER -- requirements
Module: pending_req_arbiter

---
 rtl/pending_req_arbiter.sv | 103 ++++++++++
 tb/tb_pending_req_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pending_req_arbiter.sv
// Pending-request arbiter: 16 sticky request bits, one-hot grant held until ack.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; default is fixed priority (bit 0 wins).
module pending_req_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:15] req_i,
  input  logic [0:15] en_i,
  input  logic        gnt_ack_i,
  output logic        gnt_valid_o,
  output logic [0:15] gnt_o,
  output logic [0:15] pend_o,
  output logic        ovf_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state;
  logic [0:15] pend;
  logic [0:15] elig;
  logic [0:15] clr_mask;
  logic [0:15] sel_oh;
  logic        sel_any;
  logic        ack_acc;

  assign ack_acc  = gnt_valid_o & gnt_ack_i;
  assign clr_mask = ack_acc ? gnt_o : '0;
  assign elig     = pend & en_i;
  assign pend_o   = pend;

`ifdef ARB_ROUND_ROBIN_EN
  logic [0:3] ptr;
  logic [0:3] sel_idx;
  logic [0:3] gnt_idx;

  // Scan from ptr upward; 4-bit index arithmetic wraps 15 -> 0.
  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    sel_any = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!sel_any && elig[ptr + 4'(i)]) begin
        sel_any              = 1'b1;
        sel_idx              = ptr + 4'(i);
        sel_oh[ptr + 4'(i)]  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    sel_oh  = '0;
    sel_any = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!sel_any && elig[i]) begin
        sel_any   = 1'b1;
        sel_oh[i] = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pend        <= '0;
      gnt_o       <= '0;
      gnt_valid_o <= 1'b0;
      ovf_o       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr         <= '0;
      gnt_idx     <= '0;
`endif
    end else begin
      // A new event on the bit being acked survives the clear.
      pend <= (pend & ~clr_mask) | req_i;
      if (|(req_i & pend & ~clr_mask))
        ovf_o <= 1'b1;
      case (state)
        IDLE: begin
          if (sel_any) begin
            gnt_o       <= sel_oh;
            gnt_valid_o <= 1'b1;
            state       <= GRANT;
`ifdef ARB_ROUND_ROBIN_EN
            gnt_idx     <= sel_idx;
`endif
          end
        end
        GRANT: begin
          if (gnt_ack_i) begin
            gnt_o       <= '0;
            gnt_valid_o <= 1'b0;
            state       <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            ptr         <= gnt_idx + 4'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pending_req_arbiter.sv
// Directed bench for pending_req_arbiter; vectors use [0:15] ordering (16'h8000 = bit 0).
module tb_pending_req_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [0:15] req_i;
  logic [0:15] en_i;
  logic        gnt_ack_i;
  logic        gnt_valid_o;
  logic [0:15] gnt_o;
  logic [0:15] pend_o;
  logic        ovf_o;

  int total  = 0;
  int passed = 0;

  pending_req_arbiter dut (
    .clk(clk), .rst(rst), .req_i(req_i), .en_i(en_i), .gnt_ack_i(gnt_ack_i),
    .gnt_valid_o(gnt_valid_o), .gnt_o(gnt_o), .pend_o(pend_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] g,
                         input logic [15:0] p, input logic o);
    chk({tag, ".valid"}, {15'd0, gnt_valid_o}, {15'd0, v});
    chk({tag, ".gnt"},   gnt_o,  g);
    chk({tag, ".pend"},  pend_o, p);
    chk({tag, ".ovf"},   {15'd0, ovf_o}, {15'd0, o});
  endtask

  initial begin
    rst = 1'b1; req_i = '0; en_i = 16'hFFFF; gnt_ack_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_out("reset", 1'b0, 16'h0000, 16'h0000, 1'b0);

    // single request, latency and ack
    req_i = 16'h8000; tick(); req_i = '0;
    chk_out("r025.set", 1'b0, 16'h0000, 16'h8000, 1'b0);
    tick();
    chk_out("r025.gnt", 1'b1, 16'h8000, 16'h8000, 1'b0);
    gnt_ack_i = 1'b1; tick(); gnt_ack_i = 1'b0;
    chk_out("r025.ack", 1'b0, 16'h0000, 16'h0000, 1'b0);

    // two simultaneous requests, bit 7 before bit 15
    req_i = 16'h0101; tick(); req_i = '0;
    chk_out("r026.set", 1'b0, 16'h0000, 16'h0101, 1'b0);
    tick();
    chk_out("r026.g1", 1'b1, 16'h0100, 16'h0101, 1'b0);
    gnt_ack_i = 1'b1; tick(); gnt_ack_i = 1'b0;
    chk_out("r026.a1", 1'b0, 16'h0000, 16'h0001, 1'b0);
    tick();
    chk_out("r026.g2", 1'b1, 16'h0001, 16'h0001, 1'b0);
    gnt_ack_i = 1'b1; tick(); gnt_ack_i = 1'b0;
    chk_out("r026.a2", 1'b0, 16'h0000, 16'h0000, 1'b0);

    // bits 0 and 15 held requesting
    req_i = 16'h8001; tick();
    chk("r027.pend", pend_o, 16'h8001);
    tick();
    chk("r027.g1", gnt_o, 16'h8000);
    chk("r027.ovf", {15'd0, ovf_o}, 16'h0001);
    gnt_ack_i = 1'b1; tick(); gnt_ack_i = 1'b0;
    chk("r027.a1v", {15'd0, gnt_valid_o}, 16'h0000);
    chk("r027.a1p", pend_o, 16'h8001);
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    chk("r027.g2", gnt_o, 16'h0001);
`else
    chk("r027.g2", gnt_o, 16'h8000);
`endif
    gnt_ack_i = 1'b1; tick(); gnt_ack_i = 1'b0;
    tick();
    chk("r027.g3", gnt_o, 16'h8000);
    req_i = '0; gnt_ack_i = 1'b1; tick(); gnt_ack_i = 1'b0;
    chk("r027.a3p", pend_o, 16'h0001);
    tick();
    chk("r027.g4", gnt_o, 16'h0001);
    gnt_ack_i = 1'b1; tick(); gnt_ack_i = 1'b0;
    chk_out("r027.end", 1'b0, 16'h0000, 16'h0000, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_out("rst2", 1'b0, 16'h0000, 16'h0000, 1'b0);

    // grant held while en/req change; next grant waits for enable
    req_i = 16'h0040; tick(); req_i = '0; tick();
    chk_out("r028.g", 1'b1, 16'h0040, 16'h0040, 1'b0);
    en_i = '0; req_i = 16'h8000; tick(); req_i = '0;
    chk_out("r028.hold1", 1'b1, 16'h0040, 16'h8040, 1'b0);
    tick();
    chk("r028.hold2", gnt_o, 16'h0040);
    gnt_ack_i = 1'b1; tick(); gnt_ack_i = 1'b0;
    chk_out("r028.ack", 1'b0, 16'h0000, 16'h8000, 1'b0);
    tick(); tick();
    chk_out("r028.masked", 1'b0, 16'h0000, 16'h8000, 1'b0);
    en_i = 16'hFFFF; tick();
    chk_out("r028.g2", 1'b1, 16'h8000, 16'h8000, 1'b0);
    gnt_ack_i = 1'b1; tick(); gnt_ack_i = 1'b0;
    chk("r028.end", pend_o, 16'h0000);

    // bit 5 pulsed twice -> overflow, sticky across ack
    req_i = 16'h0400; tick(); req_i = '0;
    chk("r029.ovf0", {15'd0, ovf_o}, 16'h0000);
    req_i = 16'h0400; tick(); req_i = '0;
    chk_out("r029.dup", 1'b1, 16'h0400, 16'h0400, 1'b1);
    gnt_ack_i = 1'b1; tick(); gnt_ack_i = 1'b0;
    chk_out("r029.ack", 1'b0, 16'h0000, 16'h0000, 1'b1);
    // coincident set and ack-clear on a clean overflow flag
    rst = 1'b1; tick(); rst = 1'b0;
    req_i = 16'h0400; tick(); req_i = '0; tick();
    chk("r029.g", gnt_o, 16'h0400);
    req_i = 16'h0400; gnt_ack_i = 1'b1; tick(); req_i = '0; gnt_ack_i = 1'b0;
    chk_out("r029.coin", 1'b0, 16'h0000, 16'h0400, 1'b0);
    tick();
    chk("r029.regnt", gnt_o, 16'h0400);

    // reset aborts a live grant, ignores requests; ack while idle ignored
    rst = 1'b1; tick(); rst = 1'b0;
    req_i = 16'h0F00; gnt_ack_i = 1'b1; tick(); req_i = '0; gnt_ack_i = 1'b0;
    chk_out("r018.idleack", 1'b0, 16'h0000, 16'h0F00, 1'b0);
    tick();
    chk_out("r030.g", 1'b1, 16'h0800, 16'h0F00, 1'b0);
    rst = 1'b1; req_i = 16'hFFFF; tick(); rst = 1'b0; req_i = '0;
    chk_out("r030.rst", 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick();
    chk_out("r030.idle", 1'b0, 16'h0000, 16'h0000, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
